// File: rtl/bus_mmio_if.sv
// Main-bus side of the MMIO bridge: command, write-data, read-data and error channels.
// The bridge uses the slave modport; the main bus (or a bench) uses the master modport.
interface bus_mmio_if;
  logic        bmain_cvalid_bmmio;
  logic        bmmio_cready;
  logic        bmain_cmd;
  logic [25:0] bmain_addr;
  logic        bmain_wvalid_bmmio;
  logic        bmmio_wready;
  logic        bmain_wlast;
  logic [31:0] bmain_wdata;
  logic [3:0]  bmain_wmask;
  logic        bmmio_rvalid;
  logic        bmain_rready_bmmio;
  logic [31:0] bmmio_rdata;
  logic        bmmio_error;
  logic        bmain_eack_bmmio;

  modport slave (
    input  bmain_cvalid_bmmio, bmain_cmd, bmain_addr,
    input  bmain_wvalid_bmmio, bmain_wlast, bmain_wdata, bmain_wmask,
    input  bmain_rready_bmmio, bmain_eack_bmmio,
    output bmmio_cready, bmmio_wready, bmmio_rvalid, bmmio_rdata, bmmio_error
  );

  modport master (
    output bmain_cvalid_bmmio, bmain_cmd, bmain_addr,
    output bmain_wvalid_bmmio, bmain_wlast, bmain_wdata, bmain_wmask,
    output bmain_rready_bmmio, bmain_eack_bmmio,
    input  bmmio_cready, bmmio_wready, bmmio_rvalid, bmmio_rdata, bmmio_error
  );
endinterface

// File: rtl/bus_mmio.sv
// MMIO bridge: single-beat main-bus commands to a one-hot req/ack peripheral port,
// with a watchdog that turns a silent or unmapped slot into a held bus error.
module bus_mmio #(
  parameter int NSLOTS  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk_core,
  input  logic                   reset_n,
  bus_mmio_if.slave              bus,
  output logic [NSLOTS-1:0]      mmio_req,
  output logic                   mmio_we,
  output logic [9:0]             mmio_addr,
  output logic [31:0]            mmio_wdata,
  output logic [3:0]             mmio_wmask,
  input  logic [NSLOTS-1:0]      periph_ack,
  input  logic [32*NSLOTS-1:0]   periph_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_ACCESS,
    S_RESP,
    S_ERR
  } state_t;

  localparam logic [4:0] NSLOTS_W   = 5'(NSLOTS);
  localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_cmd;
  logic [3:0]         r_slot;
  logic [9:0]         r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wmask;
  logic [31:0]        r_rdata;
  logic [7:0]         r_wdog;

  logic               w_cmd_mapped;
  logic               w_slot_mapped;
  logic               w_wdog_expired;
  logic               w_sel_ack;
  logic [31:0]        w_sel_rdata;
  logic [NSLOTS-1:0]  w_slot_onehot;
  logic               w_cready;
  logic               w_wready;
  logic               w_rvalid;
  logic               w_error;
  logic               w_unused_addr;

  // Only the slot and register fields decode; the upper window bits are don't-care.
  assign w_unused_addr  = ^bus.bmain_addr[25:14];
  assign w_cmd_mapped   = ({1'b0, bus.bmain_addr[13:10]} < NSLOTS_W);
  assign w_slot_mapped  = ({1'b0, r_slot} < NSLOTS_W);
  assign w_wdog_expired = (r_wdog == WDOG_LIMIT);

  always_comb begin
    w_sel_ack     = 1'b0;
    w_sel_rdata   = '0;
    w_slot_onehot = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (r_slot == 4'(i)) begin
        w_slot_onehot[i] = 1'b1;
        w_sel_ack        = periph_ack[i];
        w_sel_rdata      = periph_rdata[32*i +: 32];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_core) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.bmain_cvalid_bmmio) begin
          if (!bus.bmain_cmd)     w_next = S_WDATA;
          else if (w_cmd_mapped)  w_next = S_ACCESS;
          else                    w_next = S_ERR;
        end
      end
      S_WDATA: begin
        if (bus.bmain_wvalid_bmmio) begin
          if (!bus.bmain_wlast || !w_slot_mapped) w_next = S_ERR;
          else                                   w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // An ack in the final watchdog cycle still completes the access.
        if (w_sel_ack)           w_next = r_cmd ? S_RESP : S_IDLE;
        else if (w_wdog_expired) w_next = S_ERR;
      end
      S_RESP:  if (bus.bmain_rready_bmmio) w_next = S_IDLE;
      S_ERR:   if (bus.bmain_eack_bmmio)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: every comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    w_cready = 1'b0;
    w_wready = 1'b0;
    w_rvalid = 1'b0;
    w_error  = 1'b0;
    mmio_req = '0;
    mmio_we  = 1'b0;
    unique case (r_state)
      S_IDLE:   w_cready = 1'b1;
      S_WDATA:  w_wready = 1'b1;
      S_ACCESS: begin
        mmio_req = w_slot_onehot;
        mmio_we  = ~r_cmd;
      end
      S_RESP:   w_rvalid = 1'b1;
      S_ERR:    w_error  = 1'b1;
      default:  ;
    endcase
  end

  // NOTE: the datapath registers are reset too, because their values are visible on outputs.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      r_cmd   <= 1'b0;
      r_slot  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_wdog  <= '0;
    end else begin
      if (r_state == S_IDLE && bus.bmain_cvalid_bmmio) begin
        r_cmd  <= bus.bmain_cmd;
        r_slot <= bus.bmain_addr[13:10];
        r_addr <= bus.bmain_addr[9:0];
      end
      if (r_state == S_WDATA && bus.bmain_wvalid_bmmio) begin
        r_wdata <= bus.bmain_wdata;
        r_wmask <= bus.bmain_wmask;
      end
      if (r_state == S_ACCESS && r_cmd && w_sel_ack) r_rdata <= w_sel_rdata;
      r_wdog <= (r_state == S_ACCESS) ? r_wdog + 8'd1 : 8'd0;
    end
  end

  assign bus.bmmio_cready = w_cready;
  assign bus.bmmio_wready = w_wready;
  assign bus.bmmio_rvalid = w_rvalid;
  assign bus.bmmio_error  = w_error;
  assign bus.bmmio_rdata  = r_rdata;
  assign mmio_addr        = r_addr;
  assign mmio_wdata       = r_wdata;
  assign mmio_wmask       = r_wmask;

endmodule

// File: tb/tb_bus_mmio.sv
// Randomized bench for bus_mmio: a driver queues expected outcomes computed from the
// transaction rules, and an independent monitor checks the DUT outputs against them.
module tb_bus_mmio;
  localparam int NS = 4;
  localparam int TO = 8;

  typedef enum logic [1:0] {K_READ, K_WRITE, K_ERR} kind_t;
  typedef struct {
    kind_t       kind;
    bit          rd;
    logic [3:0]  slot;
    logic [9:0]  rega;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    int          lat;
    int          reqc;
  } exp_t;

  logic             clk_core = 1'b0;
  logic             reset_n  = 1'b0;
  logic [NS-1:0]    mmio_req;
  logic             mmio_we;
  logic [9:0]       mmio_addr;
  logic [31:0]      mmio_wdata;
  logic [3:0]       mmio_wmask;
  logic [NS-1:0]    periph_ack = '0;
  logic [32*NS-1:0] periph_rdata = '0;

  bus_mmio_if bus ();

  bus_mmio #(.NSLOTS(NS), .TIMEOUT(TO)) dut (
    .clk_core     (clk_core),
    .reset_n      (reset_n),
    .bus          (bus),
    .mmio_req     (mmio_req),
    .mmio_we      (mmio_we),
    .mmio_addr    (mmio_addr),
    .mmio_wdata   (mmio_wdata),
    .mmio_wmask   (mmio_wmask),
    .periph_ack   (periph_ack),
    .periph_rdata (periph_rdata)
  );

  always #5 clk_core = ~clk_core;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  int          plat[NS];
  int          pcnt[NS];
  logic [31:0] pval[NS];
  bit          spur = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  // Peripheral model: slot s acks on its (plat[s]+1)-th consecutive request cycle.
  always @(posedge clk_core) begin
    #1;
    for (int s = 0; s < NS; s++) begin
      if (mmio_req[s]) begin
        periph_ack[s] = (pcnt[s] == plat[s]);
        pcnt[s]++;
      end else begin
        pcnt[s] = 0;
        periph_ack[s] = spur && ($urandom_range(0, 3) == 0);
      end
      periph_rdata[32*s +: 32] = pval[s];
    end
  end

  // Monitor: pops an expectation per accepted command and checks the DUT against it.
  int   cyc = 0;
  int   t_cmd = 0;
  int   reqc = 0;
  bit   busy = 1'b0;
  bit   responded = 1'b0;
  exp_t cur;

  always @(negedge clk_core) begin
    logic [NS-1:0] oh;
    kind_t         got;
    cyc++;
    if (!reset_n) begin
      busy      = 1'b0;
      responded = 1'b0;
    end else begin
      if (mmio_req != '0) begin
        if (!busy || responded) begin
          check("req_outside_access", 64'(mmio_req), 64'd0);
        end else begin
          reqc++;
          oh = NS'(1) << cur.slot;
          check("access_fields",
                {mmio_req, mmio_we, mmio_addr, cur.rd ? 32'h0 : mmio_wdata, cur.rd ? 4'h0 : mmio_wmask},
                {oh, !cur.rd, cur.rega, cur.rd ? 32'h0 : cur.wdata, cur.rd ? 4'h0 : cur.wmask});
        end
      end
      if (bus.bmmio_wready && busy && cur.rd) check("wready_on_read", 64'd1, 64'd0);
      if (busy && !responded && (bus.bmmio_rvalid || bus.bmmio_error || bus.bmmio_cready)) begin
        got = bus.bmmio_rvalid ? K_READ : (bus.bmmio_error ? K_ERR : K_WRITE);
        check("resp_kind", 64'(got), 64'(cur.kind));
        check("resp_cycle", 64'(cyc - t_cmd), 64'(cur.lat));
        check("req_cycles", 64'(reqc), 64'(cur.reqc));
        if (got == K_WRITE) busy = 1'b0;
        else                responded = 1'b1;
      end
      if (busy && responded) begin
        if (cur.kind == K_READ)
          check("rdata_held", {bus.bmmio_rvalid, bus.bmmio_error, bus.bmmio_rdata}, {1'b1, 1'b0, cur.rdata});
        else
          check("error_held", {bus.bmmio_rvalid, bus.bmmio_error}, 2'b01);
        if ((bus.bmmio_rvalid && bus.bmain_rready_bmmio) || (bus.bmmio_error && bus.bmain_eack_bmmio)) begin
          busy      = 1'b0;
          responded = 1'b0;
        end
      end
      if (bus.bmain_cvalid_bmmio && bus.bmmio_cready) begin
        if (sb_q.size() == 0) begin
          check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
          cur       = sb_q.pop_front();
          busy      = 1'b1;
          responded = 1'b0;
          t_cmd     = cyc;
          reqc      = 0;
        end
      end
    end
  end

  // Reference outcome of one transaction, straight from the bridge's transaction rules.
  function automatic exp_t model(input bit rd, input logic [3:0] slot, input logic [9:0] rega,
                                 input logic [31:0] wd, input logic [3:0] wm, input bit wlast0,
                                 input int wdelay, input int lat, input logic [31:0] rdv);
    exp_t e;
    bit   mapped = (int'(slot) < NS);
    bit   in_time = (lat <= TO - 1);
    int   t_beat = 1 + wdelay;
    e.rd = rd; e.slot = slot; e.rega = rega; e.wdata = wd; e.wmask = wm; e.rdata = rdv;
    if (rd) begin
      if (!mapped)       begin e.kind = K_ERR;  e.lat = 1;      e.reqc = 0;       end
      else if (!in_time) begin e.kind = K_ERR;  e.lat = 1 + TO; e.reqc = TO;      end
      else               begin e.kind = K_READ; e.lat = 2 + lat; e.reqc = lat + 1; end
    end else begin
      if (wlast0 || !mapped) begin e.kind = K_ERR;   e.lat = t_beat + 1;       e.reqc = 0;       end
      else if (!in_time)     begin e.kind = K_ERR;   e.lat = t_beat + 1 + TO;  e.reqc = TO;      end
      else                   begin e.kind = K_WRITE; e.lat = t_beat + 2 + lat; e.reqc = lat + 1; end
    end
    return e;
  endfunction

  task automatic set_periph(input logic [3:0] slot, input int lat, input logic [31:0] rdv);
    for (int s = 0; s < NS; s++) pval[s] = $urandom;
    if (int'(slot) < NS) begin
      plat[int'(slot)] = lat;
      pval[int'(slot)] = rdv;
    end
  endtask

  task automatic send_cmd(input bit rd, input logic [3:0] slot, input logic [9:0] rega, input logic [11:0] hi);
    int n = 0;
    while (!bus.bmmio_cready && n < 50) begin step(); n++; end
    if (!bus.bmmio_cready) check("cready_wait", 64'd0, 64'd1);
    bus.bmain_cvalid_bmmio = 1'b1;
    bus.bmain_cmd          = rd;
    bus.bmain_addr         = {hi, slot, rega};
    step();
    bus.bmain_cvalid_bmmio = 1'b0;
    bus.bmain_addr         = 26'($urandom);
  endtask

  task automatic run_txn(input bit rd, input logic [3:0] slot, input logic [9:0] rega, input logic [11:0] hi,
                         input logic [31:0] wd, input logic [3:0] wm, input bit wlast0, input int wdelay,
                         input int lat, input logic [31:0] rdv, input int hold);
    int n = 0;
    int held = 0;
    bit done = 1'b0;
    set_periph(slot, lat, rdv);
    sb_q.push_back(model(rd, slot, rega, wd, wm, wlast0, wdelay, lat, rdv));
    send_cmd(rd, slot, rega, hi);
    if (!rd) begin
      repeat (wdelay) step();
      bus.bmain_wvalid_bmmio = 1'b1;
      bus.bmain_wdata        = wd;
      bus.bmain_wmask        = wm;
      bus.bmain_wlast        = !wlast0;
      step();
      if (wlast0) begin
        bus.bmain_wlast = 1'b1;
        bus.bmain_wdata = ~wd;
        step();
      end
      bus.bmain_wvalid_bmmio = 1'b0;
      bus.bmain_wlast        = 1'b0;
    end
    while (!done && n < 400) begin
      bus.bmain_rready_bmmio = bus.bmmio_rvalid && (held >= hold);
      bus.bmain_eack_bmmio   = bus.bmmio_error  && (held >= hold);
      if (bus.bmmio_rvalid || bus.bmmio_error) held++;
      if (bus.bmmio_cready) done = 1'b1;
      else begin step(); n++; end
    end
    bus.bmain_rready_bmmio = 1'b0;
    bus.bmain_eack_bmmio   = 1'b0;
    if (!done) check("txn_timeout", 64'd0, 64'd1);
  endtask

  // Reset while a read is in ACCESS (in_resp=0) or held in RESP (in_resp=1).
  task automatic reset_case(input bit in_resp);
    logic [31:0] v = $urandom;
    int lat = in_resp ? 0 : 5;
    set_periph(4'd1, lat, v);
    sb_q.push_back(model(1'b1, 4'd1, 10'd7, 32'h0, 4'h0, 1'b0, 0, lat, v));
    send_cmd(1'b1, 4'd1, 10'd7, 12'h020);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("reset_mid_txn", {mmio_req, bus.bmmio_rvalid, bus.bmmio_cready, bus.bmmio_error, bus.bmmio_rdata},
          {4'b0000, 1'b0, 1'b1, 1'b0, 32'h0});
  endtask

  initial begin
    int n;
    bus.bmain_cvalid_bmmio = 1'b0;
    bus.bmain_cmd          = 1'b0;
    bus.bmain_addr         = '0;
    bus.bmain_wvalid_bmmio = 1'b0;
    bus.bmain_wlast        = 1'b0;
    bus.bmain_wdata        = '0;
    bus.bmain_wmask        = '0;
    bus.bmain_rready_bmmio = 1'b0;
    bus.bmain_eack_bmmio   = 1'b0;
    for (int s = 0; s < NS; s++) begin plat[s] = 0; pcnt[s] = 0; pval[s] = '0; end
    repeat (3) step();
    check("reset_ctrl", {bus.bmmio_cready, bus.bmmio_wready, bus.bmmio_rvalid, bus.bmmio_error, mmio_req, mmio_we},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    check("reset_data", {mmio_addr, mmio_wdata, mmio_wmask, bus.bmmio_rdata}, 78'h0);
    reset_n = 1'b1;
    step();

    // Directed cases from the bridge's intended behaviour.
    run_txn(1'b1, 4'd1, 10'd3, 12'h020, 32'h0, 4'h0, 1'b0, 0, 2, 32'hDEADBEEF, 4);
    run_txn(1'b0, 4'd0, 10'd1, 12'h020, 32'h12345678, 4'b0011, 1'b0, 5, 0, 32'h0, 0);
    run_txn(1'b1, 4'd5, 10'd0, 12'h020, 32'h0, 4'h0, 1'b0, 0, 0, 32'h0, 3);
    run_txn(1'b1, 4'd2, 10'd0, 12'h020, 32'h0, 4'h0, 1'b0, 0, 255, 32'h0, 1);
    run_txn(1'b1, 4'd2, 10'd0, 12'h020, 32'h0, 4'h0, 1'b0, 0, TO - 1, 32'hCAFEF00D, 0);
    run_txn(1'b0, 4'd0, 10'd9, 12'h020, 32'hA5A5A5A5, 4'hF, 1'b1, 0, 0, 32'h0, 0);
    spur = 1'b1;
    run_txn(1'b1, 4'd3, 10'h3FF, 12'hFFF, 32'h0, 4'h0, 1'b0, 0, 1, 32'h0BADF00D, 3);
    run_txn(1'b0, 4'd3, 10'd4, 12'h000, 32'h01020304, 4'h0, 1'b0, 0, 0, 32'h0, 0);
    spur = 1'b0;
    reset_case(1'b0);
    run_txn(1'b1, 4'd1, 10'd3, 12'h020, 32'h0, 4'h0, 1'b0, 0, 0, 32'h11223344, 0);
    reset_case(1'b1);
    run_txn(1'b1, 4'd0, 10'd8, 12'h020, 32'h0, 4'h0, 1'b0, 0, 3, 32'h55667788, 1);

    // Randomized traffic, including unmapped slots, timeouts and spurious acks.
    for (int t = 0; t < 80; t++) begin
      int lat;
      int pick = $urandom_range(0, 9);
      lat = (pick < 6) ? $urandom_range(0, 5) : (pick == 6) ? TO - 1 : (pick == 7) ? TO : 255;
      spur = ($urandom_range(0, 2) == 0);
      run_txn(1'($urandom), 4'($urandom_range(0, 5)), 10'($urandom), 12'($urandom),
              $urandom, 4'($urandom), ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
              lat, $urandom, $urandom_range(0, 3));
    end
    spur = 1'b0;

    n = 0;
    while ((busy || sb_q.size() != 0) && n < 100) begin step(); n++; end
    if (busy || sb_q.size() != 0) check("drain_timeout", 64'd0, 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_mmio.md
# bus_mmio

MMIO bus bridge between the main system bus and the on-chip peripherals in the `0200_0000`–`0200_FFFF` window. It accepts single-beat read/write commands on the main-bus slave handshake and decodes a 4 KiB slot index. It drives a simple request/acknowledge register interface to up to `NSLOTS` peripherals and returns read data or an error. A watchdog counter converts a non-responding or unmapped slot into a bus error instead of a hang.

## Interface
- `NSLOTS`, 4, number of peripheral slots, 1..16; slot i occupies `0200_i000`–`0200_iFFF`.
- `TIMEOUT`, 255, maximum cycles in ACCESS without ack before error, 1..255.

- `clk_core` in 1: core clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `bmain_cvalid_bmmio` in 1: command valid.
- `bmmio_cready` out 1: command ready.
- `bmain_cmd` in 1: 1 = read, 0 = write.
- `bmain_addr` in 26: word address [27:2]; bits [15:12] = slot, [11:2] = register.
- `bmain_wvalid_bmmio` in 1: write data valid.
- `bmmio_wready` out 1: write data ready.
- `bmain_wlast` in 1: last write beat.
- `bmain_wdata` in 32: write data.
- `bmain_wmask` in 4: byte enables.
- `bmmio_rvalid` out 1: read data valid; every read is single beat.
- `bmain_rready_bmmio` in 1: read data ready.
- `bmmio_rdata` out 32: read data, registered.
- `bmmio_error` out 1: access fault, held until acknowledged.
- `bmain_eack_bmmio` in 1: error acknowledge.
- `mmio_req` out NSLOTS: one-hot request to the selected slot.
- `mmio_we` out 1: 1 = write.
- `mmio_addr` out 10: register word address [11:2].
- `mmio_wdata` out 32: write data.
- `mmio_wmask` out 4: byte enables.
- `periph_ack` in NSLOTS: per-slot acknowledge.
- `periph_rdata` in 32*NSLOTS: slot i data on bits [32i+31:32i], sampled on ack.

## Operation
- FSM states: IDLE, WDATA, ACCESS, RESP, ERR.
- Reset → IDLE. Output reset values: `mmio_req` = 0, `mmio_we` = 0, `mmio_addr` = 0, `mmio_wdata` = 0, `mmio_wmask` = 0, `bmmio_rdata` = 0, `bmmio_rvalid` = 0, `bmmio_error` = 0, `bmmio_wready` = 0. `bmmio_cready` = 1, since it is decoded from IDLE.
- `bmmio_cready` = (state == IDLE). A command beat latches cmd, addr[15:2], and slot = addr[15:12]. Address bits [27:16] are ignored.
- Read command:
  - Slot < NSLOTS → ACCESS.
  - Otherwise → ERR.
- Write command → WDATA.
- WDATA: `bmmio_wready` = 1. The beat latches wdata and wmask.
  - `wlast` = 0 → ERR; the beat is consumed and discarded.
  - Slot unmapped → ERR.
  - Otherwise → ACCESS.
  - `wvalid` outside WDATA is not accepted.
- ACCESS:
  - `mmio_req[slot]` = 1, all other bits 0.
  - `mmio_we` = ~cmd. `mmio_addr`, `mmio_wdata`, and `mmio_wmask` are stable for the whole state.
  - The watchdog clears on entry and increments each cycle.
  - `periph_ack[slot]` on a read: latch the selected `periph_rdata` into `bmmio_rdata` → RESP.
  - `periph_ack[slot]` on a write: → IDLE.
  - No ack and count == TIMEOUT−1: drop req → ERR.
  - Ack in the same cycle as the timeout: the ack wins.
  - Acks from non-selected slots, or in any other state, are ignored.
- `wmask` = 0 still issues the access; interpreting it is the peripheral's job.
- RESP: `bmmio_rvalid` = 1 and `bmmio_rdata` is held until `bmain_rready_bmmio` → IDLE.
- ERR: `bmmio_error` = 1 until `bmain_eack_bmmio` → IDLE. No rvalid and no req are asserted in ERR.
- Only one transaction is outstanding at a time; there is no pipelining.
- Synchronous reset in any state forces IDLE and the reset values next cycle. An in-flight peripheral request is abandoned.

## Timing
- Read, zero-wait peripheral:
  - Command beat at cycle 0.
  - `mmio_req` at cycle 1; ack at cycle 1.
  - `bmmio_rvalid` at cycle 2.
  - With rready = 1 at cycle 2, `bmmio_cready` at cycle 3.
- Write, zero-wait:
  - Command beat at cycle 0.
  - `wready` at cycle 1; data beat at cycle 1.
  - req/ack at cycle 2.
  - `cready` at cycle 3.
- An N-cycle wait peripheral adds N cycles in ACCESS.
- Timeout: req is asserted for exactly TIMEOUT cycles, then `bmmio_error` on the following cycle.
- Unmapped read: `bmmio_error` at cycle 1, no `mmio_req` ever.
- All outputs are registered or decoded from the state register only. Nothing is combinational from bus inputs to bus outputs.

## Test plan
- Read slot 1 reg 3 (addr `0200_100C`), peripheral acks after 2 cycles with `DEADBEEF` → `mmio_req` = 0010 for 3 cycles, `mmio_addr` = 3, `mmio_we` = 0; rvalid with `DEADBEEF`. rdata held while rready is low for 4 cycles.
- Write `0200_0004` data `12345678` mask 0011, wvalid delayed 5 cycles after the command → wready only in WDATA; req = 0001 with `mmio_we` = 1, wdata/wmask exact; `cready` returns 1 cycle after ack.
- Read `0200_5000` with NSLOTS = 4 → no req, error at cycle 1 held through 3 cycles of eack = 0, IDLE after eack.
- Slot 2 never acks, TIMEOUT = 8 → req high exactly 8 cycles, then error. Repeat with the ack on the 8th cycle → read completes normally with no error.
- Two-beat write (first `wlast` = 0) → first beat consumed, ERR, no req. Spurious `periph_ack` pulses in IDLE/RESP are ignored.
- Assert `reset_n` = 0 during ACCESS and during RESP → next cycle req = 0, rvalid = 0, cready = 1; the following read completes correctly.
